// File: rtl/regfile_writeback.sv
// ============================================================================
// Module   : regfile_writeback
// Purpose  : In-order writeback queue that drains up to two results per cycle
//            onto a two-port register file. It coalesces same-address pairs and
//            offers a bypass lookup of pending results.
// Config   : define REGFILE_WB_BYPASS_EN to build the bypass lookup logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         hold,
    output logic [ADDR_W-1:0]            wr1,
    output logic [DATA_W-1:0]            wr1_data,
    output logic                         wr1_enable,
    output logic [ADDR_W-1:0]            wr2,
    output logic [DATA_W-1:0]            wr2_data,
    output logic                         wr2_enable,
    input  logic [ADDR_W-1:0]            byp_addr,
    output logic                         byp_hit,
    output logic [DATA_W-1:0]            byp_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                PTR_W  = $clog2(DEPTH);
    localparam int                CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] wr1_q, wr1_d, wr2_q, wr2_d;
    logic [DATA_W-1:0] wr1_data_q, wr1_data_d, wr2_data_q, wr2_data_d;
    logic              wr1_en_q, wr1_en_d, wr2_en_q, wr2_en_d;
    logic              push;
    logic [CNT_W-1:0]  pops;
    logic [PTR_W-1:0]  rd_nxt;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign in_ready = (count_q != C_FULL);
    assign push     = in_valid && in_ready;
    assign rd_nxt   = rd_ptr_q + PTR_W'(1);

    always_comb begin
        pops       = '0;
        wr1_d      = wr1_q;
        wr1_data_d = wr1_data_q;
        wr1_en_d   = 1'b0;
        wr2_d      = wr2_q;
        wr2_data_d = wr2_data_q;
        wr2_en_d   = 1'b0;
        if (!hold && (count_q != '0)) begin
            if (count_q == CNT_W'(1)) begin
                pops       = CNT_W'(1);
                wr1_d      = addr_q[rd_ptr_q];
                wr1_data_d = data_q[rd_ptr_q];
                wr1_en_d   = 1'b1;
            end else begin
                pops       = CNT_W'(2);
                wr2_d      = addr_q[rd_nxt];
                wr2_data_d = data_q[rd_nxt];
                wr2_en_d   = 1'b1;
                // Same destination: the older value is dead, only port 2 writes.
                if (addr_q[rd_ptr_q] != addr_q[rd_nxt]) begin
                    wr1_d      = addr_q[rd_ptr_q];
                    wr1_data_d = data_q[rd_ptr_q];
                    wr1_en_d   = 1'b1;
                end
            end
        end
        count_d  = count_q + CNT_W'(push) - pops;
        rd_ptr_d = rd_ptr_q + PTR_W'(pops);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wr1_q      <= '0;
            wr1_data_q <= '0;
            wr1_en_q   <= 1'b0;
            wr2_q      <= '0;
            wr2_data_q <= '0;
            wr2_en_q   <= 1'b0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= in_addr;
                data_q[wr_ptr_q] <= in_data;
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wr1_q      <= wr1_d;
            wr1_data_q <= wr1_data_d;
            wr1_en_q   <= wr1_en_d;
            wr2_q      <= wr2_d;
            wr2_data_q <= wr2_data_d;
            wr2_en_q   <= wr2_en_d;
        end
    end

    assign wr1        = wr1_q;
    assign wr1_data   = wr1_data_q;
    assign wr1_enable = wr1_en_q;
    assign wr2        = wr2_q;
    assign wr2_data   = wr2_data_q;
    assign wr2_enable = wr2_en_q;
    assign count      = count_q;

`ifdef REGFILE_WB_BYPASS_EN
    logic              byp_hit_c;
    logic [DATA_W-1:0] byp_data_c;

    // Lowest priority first so later matches override: port 1, port 2, then queue oldest-to-newest.
    always_comb begin
        byp_hit_c  = 1'b0;
        byp_data_c = '0;
        if (wr1_en_q && (wr1_q == byp_addr)) begin
            byp_hit_c  = 1'b1;
            byp_data_c = wr1_data_q;
        end
        if (wr2_en_q && (wr2_q == byp_addr)) begin
            byp_hit_c  = 1'b1;
            byp_data_c = wr2_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (addr_q[rd_ptr_q + PTR_W'(i)] == byp_addr)) begin
                byp_hit_c  = 1'b1;
                byp_data_c = data_q[rd_ptr_q + PTR_W'(i)];
            end
        end
    end

    assign byp_hit  = byp_hit_c;
    assign byp_data = byp_data_c;
`else
    logic byp_unused;
    assign byp_unused = ^byp_addr;
    assign byp_hit    = 1'b0;
    assign byp_data   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Self-checking bench for regfile_writeback against a queue-based
//            behavioural model, with directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              hold = 1'b0;
    logic [ADDR_W-1:0] wr1, wr2;
    logic [DATA_W-1:0] wr1_data, wr2_data;
    logic              wr1_enable, wr2_enable;
    logic [ADDR_W-1:0] byp_addr = '0;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [CNT_W-1:0]  count;

    regfile_writeback #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .hold       (hold),
        .wr1        (wr1),
        .wr1_data   (wr1_data),
        .wr1_enable (wr1_enable),
        .wr2        (wr2),
        .wr2_data   (wr2_data),
        .wr2_enable (wr2_enable),
        .byp_addr   (byp_addr),
        .byp_hit    (byp_hit),
        .byp_data   (byp_data),
        .count      (count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Reference model: an ordered list of pending results plus the write-port image.
    ent_t              mq[$];
    logic [ADDR_W-1:0] m_wr1, m_wr2;
    logic [DATA_W-1:0] m_wr1_d, m_wr2_d;
    logic              m_wr1_en, m_wr2_en;
    bit                track = 0;
    ent_t              pushed[$];
    ent_t              written[$];

    task automatic model_reset();
        mq.delete();
        m_wr1 = '0; m_wr1_d = '0; m_wr1_en = 1'b0;
        m_wr2 = '0; m_wr2_d = '0; m_wr2_en = 1'b0;
    endtask

    task automatic model_edge();
        int   n;
        bit   accept;
        ent_t e0, e1;
        n      = mq.size();
        accept = in_valid && (n != DEPTH);
        if (hold || n == 0) begin
            m_wr1_en = 1'b0;
            m_wr2_en = 1'b0;
        end else if (n == 1) begin
            e0 = mq.pop_front();
            m_wr1 = e0.a; m_wr1_d = e0.d; m_wr1_en = 1'b1;
            m_wr2_en = 1'b0;
        end else begin
            e0 = mq.pop_front();
            e1 = mq.pop_front();
            if (e0.a == e1.a) m_wr1_en = 1'b0;
            else begin
                m_wr1 = e0.a; m_wr1_d = e0.d; m_wr1_en = 1'b1;
            end
            m_wr2 = e1.a; m_wr2_d = e1.d; m_wr2_en = 1'b1;
        end
        if (accept) begin
            mq.push_back(ent_t'({in_addr, in_data}));
            if (track) pushed.push_back(ent_t'({in_addr, in_data}));
        end
    endtask

    task automatic model_byp(output logic hit, output logic [DATA_W-1:0] val);
        hit = 1'b0;
        val = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == byp_addr) begin
                hit = 1'b1; val = mq[i].d;
                return;
            end
        end
        if (m_wr2_en && m_wr2 == byp_addr) begin
            hit = 1'b1; val = m_wr2_d;
        end else if (m_wr1_en && m_wr1 == byp_addr) begin
            hit = 1'b1; val = m_wr1_d;
        end
    endtask

    task automatic compare_all();
        logic              hit;
        logic [DATA_W-1:0] val;
        model_byp(hit, val);
`ifndef REGFILE_WB_BYPASS_EN
        hit = 1'b0;
        val = '0;
`endif
        chk("count",      count,      mq.size());
        chk("in_ready",   in_ready,   mq.size() != DEPTH);
        chk("wr1_enable", wr1_enable, m_wr1_en);
        chk("wr1",        wr1,        m_wr1);
        chk("wr1_data",   wr1_data,   m_wr1_d);
        chk("wr2_enable", wr2_enable, m_wr2_en);
        chk("wr2",        wr2,        m_wr2);
        chk("wr2_data",   wr2_data,   m_wr2_d);
        chk("byp_hit",    byp_hit,    hit);
        chk("byp_data",   byp_data,   val);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
        if (track) begin
            if (wr1_enable) written.push_back(ent_t'({wr1, wr1_data}));
            if (wr2_enable) written.push_back(ent_t'({wr2, wr2_data}));
        end
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic h);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        hold     = h;
        byp_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_hit;
        model_reset();
        #2;
        compare_all();
        chk("rst_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Single push: visible on port 1 in the cycle after the pop edge, for one cycle.
        drive(1'b1, 2'd1, 8'h5A, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        step();
        chk("lat_wr1_en", wr1_enable, 1);
        chk("lat_wr1",    wr1,        1);
        chk("lat_wr1_d",  wr1_data,   8'h5A);
        chk("lat_wr2_en", wr2_enable, 0);
        step();
        chk("lat_wr1_off", wr1_enable, 0);
        idle(2);

        // Fill under hold, then drain two per cycle.
        drive(1'b1, 2'd0, 8'h11, 1'b1); step();
        drive(1'b1, 2'd1, 8'h22, 1'b1); step();
        drive(1'b1, 2'd2, 8'h33, 1'b1); step();
        drive(1'b1, 2'd3, 8'h44, 1'b1); step();
        chk("full_count", count, 4);
        chk("full_ready", in_ready, 0);
        drive(1'b0, '0, '0, 1'b0);
        step();
        chk("drain1_wr1", {wr1_enable, wr1, wr1_data}, {1'b1, 2'd0, 8'h11});
        chk("drain1_wr2", {wr2_enable, wr2, wr2_data}, {1'b1, 2'd1, 8'h22});
        step();
        chk("drain2_wr1", {wr1_enable, wr1, wr1_data}, {1'b1, 2'd2, 8'h33});
        chk("drain2_wr2", {wr2_enable, wr2, wr2_data}, {1'b1, 2'd3, 8'h44});
        chk("drain_count", count, 0);
        idle(2);

        // Same-address pair coalesces onto port 2.
        drive(1'b1, 2'd2, 8'hAA, 1'b1); step();
        drive(1'b1, 2'd2, 8'hBB, 1'b1); step();
        drive(1'b0, '0, '0, 1'b0);
        step();
        chk("coal_wr1_en", wr1_enable, 0);
        chk("coal_wr2",    {wr2_enable, wr2, wr2_data}, {1'b1, 2'd2, 8'hBB});
        idle(2);

        // Bypass returns the newest pending value.
        drive(1'b1, 2'd3, 8'h01, 1'b1); step();
        drive(1'b1, 2'd3, 8'h02, 1'b1); step();
        drive(1'b0, '0, '0, 1'b1);
        byp_addr = 2'd3;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif
        chk("byp3_hit",  byp_hit,  exp_hit);
        chk("byp3_data", byp_data, exp_hit ? 8'h02 : 8'h00);
        byp_addr = 2'd0;
        #1;
        chk("byp0_hit",  byp_hit,  0);
        chk("byp0_data", byp_data, 0);
        compare_all();
        idle(3);

        // Asynchronous reset mid-drain drops everything.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, ADDR_W'(i), DATA_W'($urandom), 1'b1);
            step();
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_en",    {wr1_enable, wr2_enable}, 0);
        compare_all();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("post_rst_en", {wr1_enable, wr2_enable}, 0);
        end

        // Sustained streaming: no stalls, order preserved, nothing lost or duplicated.
        track = 1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, ADDR_W'($urandom), DATA_W'($urandom), 1'b0);
            step();
            chk("stream_ready", in_ready, 1);
        end
        idle(4);
        track = 0;
        chk("stream_len", written.size(), pushed.size());
        for (int i = 0; i < pushed.size() && i < written.size(); i++)
            chk("stream_elem", written[i], pushed[i]);

        // Random traffic with intermittent hold.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ADDR_W'($urandom), DATA_W'($urandom),
                  ($urandom % 3) == 0);
            step();
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback buffer sitting between the execute stage and the two-write-port register file. Accepts results over a valid/ready handshake, queues them in order, and drains up to two per cycle onto the register file write ports (`wr1`/`wr2`, `wr*_data`, `wr*_enable`). It also exposes a bypass lookup so the read stage can see results that have not yet reached the register file.

## Interface
Parameters:
- `DATA_W`, 8: register data width.
- `ADDR_W`, 2: register index width; there are 2^ADDR_W registers.
- `DEPTH`, 4: queue entries; a power of two, minimum 2.

Ports:
- `clock`, in, 1: single clock; all state updates on posedge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: a result is offered.
- `in_ready`, out, 1: the queue can accept the offered result.
- `in_addr`, in, ADDR_W: destination register of the offered result.
- `in_data`, in, DATA_W: result value.
- `hold`, in, 1: when high, no pops occur this cycle.
- `wr1`, out, ADDR_W: write port 1 address (older entry).
- `wr1_data`, out, DATA_W: write port 1 data.
- `wr1_enable`, out, 1: write port 1 strobe.
- `wr2`, out, ADDR_W: write port 2 address (newer entry).
- `wr2_data`, out, DATA_W: write port 2 data.
- `wr2_enable`, out, 1: write port 2 strobe.
- `byp_addr`, in, ADDR_W: register index to look up.
- `byp_hit`, out, 1: a pending write exists for `byp_addr`.
- `byp_data`, out, DATA_W: newest pending value for `byp_addr`.
- `count`, out, clog2(DEPTH+1): current queue occupancy.

## Operation
- Queue: circular buffer with read and write pointers and `count`. Pointers wrap modulo DEPTH.
- Push:
  - A push occurs when `in_valid && in_ready`.
  - `in_ready = (count != DEPTH)`. It is driven from registered state only, never from the same-cycle pop.
- Pop, evaluated on occupancy at the start of the cycle; entries pushed this cycle are not eligible:
  - `hold` = 1, or `count` = 0: no pop. Both `wr*_enable` go to 0 at the next edge.
  - `count` = 1: pop the oldest entry to port 1.
  - `count` ≥ 2 and the two oldest entries have different addresses: pop both. Oldest goes to port 1, next goes to port 2.
  - `count` ≥ 2 and the two oldest entries have the same address: pop both (coalesce). Only the newer entry is written, on port 2; `wr1_enable` = 0.
- Write port outputs are registered and loaded at the pop edge. The `wr*` address and data outputs hold their last values when their enable is 0.
- `count` next value = `count` + push − pops. A simultaneous push and pop is legal whenever `count` < DEPTH.
- Bypass (combinational) searches in priority order:
  1. Queue entries, newest first.
  2. Output stage port 2, if `wr2_enable`.
  3. Output stage port 1, if `wr1_enable`.
  - First match sets `byp_hit` = 1 and `byp_data` to that value.
  - No match gives `byp_hit` = 0 and `byp_data` = 0.
  - The offered-but-not-yet-accepted input is never searched.

## Timing
- Reset state:
  - `count` = 0; pointers = 0; `in_ready` = 1.
  - All `wr*` outputs, `wr*_data` and `wr*_enable` = 0.
  - `byp_hit` = 0, `byp_data` = 0.
- Reset asserted mid-operation discards all queued and output-stage entries immediately, with no writes issued.
- Latency: an entry accepted at edge E0 is popped at E1 at the earliest. Its enable is high in the cycle after E1, so the register file captures it at E2.
- Throughput: 2 writes per cycle sustained, 1 accept per cycle. The queue therefore drains faster than it fills unless `hold` is asserted.
- Full: at `count` = DEPTH, `in_ready` = 0 for the whole cycle even if a pop occurs in that cycle.
- Empty: at `count` = 0, a push and no pop; `count` becomes 1.

## Configuration
- `REGFILE_WB_BYPASS_EN`:
  - Defined: the bypass comparators and mux are built as described above.
  - Undefined: the comparators are not built; `byp_hit` and `byp_data` are tied to 0 and `byp_addr` is ignored.
- Queue and write-port behaviour is identical in both builds.

## Test plan
- Reset, then push (addr 1, 0x5A) for one cycle → at E2, `wr1` = 1, `wr1_data` = 0x5A, `wr1_enable` = 1 for exactly one cycle; `wr2_enable` = 0.
- With `hold` = 1, push (0,0x11), (1,0x22), (2,0x33), (3,0x44) → `count` = 4, `in_ready` = 0. Release `hold` → one cycle later ports carry (0,0x11)/(1,0x22), the next cycle (2,0x33)/(3,0x44), and `count` reaches 0.
- With `hold` = 1, push (2,0xAA) then (2,0xBB), release → one cycle with `wr1_enable` = 0, `wr2_enable` = 1, `wr2` = 2, `wr2_data` = 0xBB.
- With `hold` = 1, queue (3,0x01), (3,0x02), set `byp_addr` = 3 → `byp_hit` = 1, `byp_data` = 0x02. With `byp_addr` = 0 → `byp_hit` = 0, `byp_data` = 0. With the macro undefined, `byp_hit` = 0 in both cases.
- Fill the queue to DEPTH, assert `reset_n` = 0 mid-drain → `count` = 0, `wr*_enable` = 0 immediately, and no further writes after release.
- Push every cycle for 20 cycles with `hold` = 0 → `in_ready` never drops, and the write sequence on the ports matches push order with no loss or duplication.
